// File: rtl/fixed_pt_pkg.sv
// Shared fixed-point definitions for the RMS front-end: default word format,
// the saturation limit and the controller state encoding.
package fixed_pt_pkg;

  localparam int N_DEF = 22;
  localparam int Q_DEF = 10;

  typedef logic signed [N_DEF-1:0] q_word_t;

  localparam q_word_t MAX_POS = q_word_t'((2 ** (N_DEF - 1)) - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACCUM     = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_MEAN      = 3'd3,
    ST_SQRT_REQ  = 3'd4,
    ST_SQRT_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } rms_state_t;

endpackage

// File: rtl/sq_mac.sv
// Square-and-accumulate datapath: registers x*x on each enabled cycle and
// adds that registered product into an unsigned accumulator one cycle later.
module sq_mac #(
  parameter int N     = 22,
  parameter int ACC_W = 2 * N + 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N-1:0]     data,
  output logic [ACC_W-1:0] acc
);

  logic signed [2*N-1:0] data_ext;
  logic signed [2*N-1:0] sq;
  logic        [2*N-1:0] prod;
  logic                  prod_vld;

  // Sign-extend first so the square is formed at full 2N-bit precision.
  assign data_ext = {{N{data[N-1]}}, data};
  assign sq       = data_ext * data_ext;

  // Product register and accumulator; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) begin
        prod <= sq;
      end else begin
        prod <= prod;
      end
      if (prod_vld) begin
        acc <= acc + ACC_W'(prod);
      end else begin
        acc <= acc;
      end
    end
  end

endmodule

// File: rtl/rms_accum.sv
// RMS front-end: accumulates x^2 over LEN samples, forms the saturated mean
// square and drives the sqrt unit. Define RMS_ROUND_NEAREST_EN for round-half-up mean.
module rms_accum
  import fixed_pt_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int Q   = Q_DEF,
  parameter int LEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data_q,
  output logic         sqrt_start,
  output logic [N-1:0] sqrt_rad_q,
  input  logic         sqrt_busy,
  input  logic         sqrt_done,
  input  logic         sqrt_neg_rad,
  input  logic [N-1:0] sqrt_root_q,
  output logic         done,
  output logic         overflow,
  output logic [N-1:0] mean_sq_q,
  output logic [N-1:0] rms_q
);

  localparam int LEN_W  = $clog2(LEN);
  localparam int ACC_W  = 2 * N + LEN_W;
  localparam int MEAN_W = ACC_W + 1;
  localparam int SH     = Q + LEN_W;
  localparam logic [N-1:0] MAX_Q = {1'b0, {(N-1){1'b1}}};

  rms_state_t        state;
  logic [LEN_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [MEAN_W-1:0] mean_full;
  logic [N-1:0]      mean_sat;
  logic              mean_ovf;
  logic              hs;
  logic              last_hs;

  assign hs      = in_valid && in_ready;
  assign last_hs = hs && (cnt == LEN_W'(LEN - 1));

  sq_mac #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst_n),
    .clr  (state == ST_IDLE),
    .en   (hs),
    .data (in_data_q),
    .acc  (acc)
  );

  // The start pulse follows sqrt_busy directly so it lands in the cycle the unit frees up.
  assign sqrt_start = (state == ST_SQRT_REQ) && !sqrt_busy && !rst_n;

  // Mean square: divide by LEN and drop the doubled fraction bits, then saturate.
  always_comb begin
    mean_full = '0;
`ifdef RMS_ROUND_NEAREST_EN
    mean_full = ({1'b0, acc} + (MEAN_W'(1) << (SH - 1))) >> SH;
`else
    mean_full = {1'b0, acc} >> SH;
`endif
    if (mean_full > MEAN_W'(MAX_Q)) begin
      mean_sat = MAX_Q;
      mean_ovf = 1'b1;
    end else begin
      mean_sat = mean_full[N-1:0];
      mean_ovf = 1'b0;
    end
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      mean_sq_q  <= '0;
      rms_q      <= '0;
      sqrt_rad_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            state     <= ST_ACCUM;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
            overflow  <= 1'b0;
            mean_sq_q <= '0;
            rms_q     <= '0;
          end
        end
        ST_ACCUM: begin
          if (hs) begin
            cnt <= cnt + LEN_W'(1);
          end
          if (last_hs) begin
            in_ready <= 1'b0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_MEAN;
        end
        ST_MEAN: begin
          mean_sq_q  <= mean_sat;
          sqrt_rad_q <= mean_sat;
          overflow   <= mean_ovf;
          state      <= ST_SQRT_REQ;
        end
        ST_SQRT_REQ: begin
          if (!sqrt_busy) begin
            state <= ST_SQRT_WAIT;
          end
        end
        ST_SQRT_WAIT: begin
          if (sqrt_done) begin
            if (sqrt_neg_rad) begin
              rms_q    <= '0;
              overflow <= 1'b1;
            end else begin
              rms_q <= sqrt_root_q;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rms_accum.sv
// Self-checking bench for rms_accum (LEN=4) with a fixed-latency floor-sqrt model.
module tb_rms_accum;
  import fixed_pt_pkg::*;

  localparam int N      = 22;
  localparam int Q      = 10;
  localparam int LEN    = 4;
  localparam int SQ_LAT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         sqrt_start;
  logic [N-1:0] sqrt_rad_q;
  logic         sqrt_busy;
  logic         sqrt_done = 1'b0;
  logic         sqrt_neg_rad = 1'b0;
  logic [N-1:0] sqrt_root_q = '0;
  logic         done;
  logic         overflow;
  logic [N-1:0] mean_sq_q;
  logic [N-1:0] rms_q;

  int total = 0;
  int bad = 0;

  // sqrt unit model state
  int           tmr = 0;
  logic         force_busy = 1'b0;
  logic         inject_neg = 1'b0;
  logic         st_seen;
  logic [N-1:0] rad_cap;
  logic [N-1:0] pend_rad = '0;

  // stimulus vector and captured results of one run
  int           vec [LEN];
  int           r_done_cyc, r_hs, r_last_hs, r_ss_cnt, r_ss_first;
  logic         r_busy1, r_done_next, r_ovf;
  logic [N-1:0] r_mean, r_rms, r_rad;

  rms_accum #(.N(N), .Q(Q), .LEN(LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data_q    (in_data),
    .sqrt_start   (sqrt_start),
    .sqrt_rad_q   (sqrt_rad_q),
    .sqrt_busy    (sqrt_busy),
    .sqrt_done    (sqrt_done),
    .sqrt_neg_rad (sqrt_neg_rad),
    .sqrt_root_q  (sqrt_root_q),
    .done         (done),
    .overflow     (overflow),
    .mean_sq_q    (mean_sq_q),
    .rms_q        (rms_q)
  );

  always #5 clk = ~clk;

  function automatic longint isqrt(input longint v);
    longint r = 0;
    longint t;
    for (int b = 20; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // Reference mean square straight from the arithmetic definition.
  function automatic longint ref_mean(output bit sat);
    longint sum = 0;
    longint m;
    for (int k = 0; k < LEN; k++) sum += longint'(vec[k]) * longint'(vec[k]);
`ifdef RMS_ROUND_NEAREST_EN
    m = (sum + ((longint'(LEN) << Q) / 2)) / (longint'(LEN) << Q);
`else
    m = sum / (longint'(LEN) << Q);
`endif
    sat = (m > longint'(MAX_POS));
    if (sat) m = longint'(MAX_POS);
    return m;
  endfunction

  assign sqrt_busy = force_busy || (tmr != 0);

  // sqrt unit: start is sampled at the edge, done arrives SQ_LAT cycles after the start cycle.
  always begin
    @(posedge clk);
    st_seen = sqrt_start;
    rad_cap = sqrt_rad_q;
    #1;
    sqrt_done    = 1'b0;
    sqrt_neg_rad = 1'b0;
    if (tmr > 0) begin
      tmr = tmr - 1;
      if (tmr == 0) begin
        sqrt_done = 1'b1;
        if (inject_neg) begin
          sqrt_neg_rad = 1'b1;
          sqrt_root_q  = N'(22'h1234);
        end else begin
          sqrt_root_q = N'(isqrt(longint'(pend_rad) << Q));
        end
      end
    end
    if (st_seen === 1'b1) begin
      tmr      = SQ_LAT - 1;
      pend_rad = rad_cap;
    end
  end

  // Drives one vector (cycle 0 = start cycle) and records what the DUT did.
  task automatic run_vec(input int stall, input int restart_at, input int busy_lo,
                         input int busy_hi, input bit neg);
    int idx = 0;
    r_done_cyc = -1; r_hs = 0; r_last_hs = -1; r_ss_cnt = 0; r_ss_first = -1;
    r_busy1 = 1'b0; r_done_next = 1'b0; r_ovf = 1'b0;
    r_mean = '0; r_rms = '0; r_rad = '0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; inject_neg = neg;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      start      = (i == restart_at);
      force_busy = (i >= busy_lo) && (i < busy_hi);
      case (stall)
        0: in_valid = 1'b1;
        1: in_valid = ((i - 1) % 3 == 0);
        default: in_valid = ($urandom_range(0, 1) == 1);
      endcase
      in_data = (idx < LEN) ? N'(vec[idx]) : N'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        r_hs++; r_last_hs = i; idx++;
      end
      if (i == 1) r_busy1 = busy;
      if (sqrt_start) begin
        r_ss_cnt++;
        if (r_ss_first < 0) r_ss_first = i;
      end
      if (done) begin
        r_done_cyc = i; r_mean = mean_sq_q; r_rms = rms_q;
        r_rad = sqrt_rad_q; r_ovf = overflow;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; force_busy = 1'b0;
    @(negedge clk);
    r_done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (sqrt_start !== 1'b0) begin bad++; $display("FAIL reset_sqrt_start got=%b exp=0", sqrt_start); end
    #1; rst_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags busy=%b in_ready=%b done=%b ovf=%b exp all 0", busy, in_ready, done, overflow); end
    total++; if (mean_sq_q !== '0 || rms_q !== '0 || sqrt_rad_q !== '0 || sqrt_start !== 1'b0) begin
      bad++; $display("FAIL reset_data mean=%0d rms=%0d rad=%0d ss=%b exp all 0", mean_sq_q, rms_q, sqrt_rad_q, sqrt_start); end
  endtask

  task automatic test_nominal();
    bit es; longint em, er;
    for (int k = 0; k < LEN; k++) vec[k] = 2048;
    em = ref_mean(es); er = isqrt(em << Q);
    run_vec(0, 0, 0, 0, 1'b0);
    total++; if (r_mean !== N'(em)) begin bad++; $display("FAIL nominal_mean got=%0d exp=%0d", r_mean, em); end
    total++; if (r_rad !== N'(em)) begin bad++; $display("FAIL nominal_rad got=%0d exp=%0d", r_rad, em); end
    total++; if (r_rms !== N'(er)) begin bad++; $display("FAIL nominal_rms got=%0d exp=%0d", r_rms, er); end
    total++; if (r_ovf !== es) begin bad++; $display("FAIL nominal_ovf got=%b exp=%b", r_ovf, es); end
    total++; if (r_done_cyc != LEN + 4 + SQ_LAT) begin bad++; $display("FAIL nominal_latency got=%0d exp=%0d", r_done_cyc, LEN + 4 + SQ_LAT); end
    total++; if (r_done_next !== 1'b0) begin bad++; $display("FAIL nominal_done_pulse got=%b exp=0", r_done_next); end
    total++; if (r_ss_cnt != 1 || r_ss_first != LEN + 3) begin bad++; $display("FAIL nominal_sqrt_start cnt=%0d first=%0d exp 1 at %0d", r_ss_cnt, r_ss_first, LEN + 3); end
    total++; if (r_hs != LEN || r_busy1 !== 1'b1) begin bad++; $display("FAIL nominal_hs hs=%0d busy1=%b exp %0d,1", r_hs, r_busy1, LEN); end
  endtask

  task automatic test_mixed();
    bit es; longint em, er;
    vec[0] = 1024; vec[1] = -1024; vec[2] = 3072; vec[3] = -3072;
    em = ref_mean(es); er = isqrt(em << Q);
    run_vec(0, 0, 0, 0, 1'b0);
    total++; if (r_mean !== N'(em) || em != 5120) begin bad++; $display("FAIL mixed_mean got=%0d exp=%0d", r_mean, em); end
    total++; if (r_rms !== N'(er)) begin bad++; $display("FAIL mixed_rms got=%0d exp=%0d", r_rms, er); end
    total++; if (r_ovf !== 1'b0) begin bad++; $display("FAIL mixed_ovf got=%b exp=0", r_ovf); end
  endtask

  task automatic test_saturate();
    bit es; longint em, er;
    for (int k = 0; k < LEN; k++) vec[k] = 2097151;
    em = ref_mean(es); er = isqrt(em << Q);
    run_vec(0, 0, 0, 0, 1'b0);
    total++; if (r_mean !== N'(em) || r_rad !== N'(em)) begin bad++; $display("FAIL sat_mean mean=%0d rad=%0d exp=%0d", r_mean, r_rad, em); end
    total++; if (r_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", r_ovf); end
    total++; if (r_rms !== N'(er)) begin bad++; $display("FAIL sat_rms got=%0d exp=%0d", r_rms, er); end
  endtask

  task automatic test_backpressure();
    bit es; longint em, er;
    for (int k = 0; k < LEN; k++) vec[k] = 2048;
    em = ref_mean(es); er = isqrt(em << Q);
    run_vec(1, 5, 0, 0, 1'b0);
    total++; if (r_hs != LEN) begin bad++; $display("FAIL bp_hs got=%0d exp=%0d", r_hs, LEN); end
    total++; if (r_last_hs != 1 + 3 * (LEN - 1)) begin bad++; $display("FAIL bp_last_hs got=%0d exp=%0d", r_last_hs, 1 + 3 * (LEN - 1)); end
    total++; if (r_mean !== N'(em) || r_rms !== N'(er) || r_ovf !== 1'b0) begin
      bad++; $display("FAIL bp_result mean=%0d rms=%0d ovf=%b exp %0d %0d 0", r_mean, r_rms, r_ovf, em, er); end
    total++; if (r_done_cyc != r_last_hs + 4 + SQ_LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", r_done_cyc, r_last_hs + 4 + SQ_LAT); end
  endtask

  task automatic test_sqrt_busy_neg();
    bit es; longint em;
    for (int k = 0; k < LEN; k++) vec[k] = 2048;
    em = ref_mean(es);
    run_vec(0, 0, LEN + 2, LEN + 8, 1'b1);
    total++; if (r_ss_cnt != 1 || r_ss_first != LEN + 8) begin bad++; $display("FAIL busy_sqrt_start cnt=%0d first=%0d exp 1 at %0d", r_ss_cnt, r_ss_first, LEN + 8); end
    total++; if (r_done_cyc != LEN + 9 + SQ_LAT) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", r_done_cyc, LEN + 9 + SQ_LAT); end
    total++; if (r_rms !== '0 || r_ovf !== 1'b1) begin bad++; $display("FAIL neg_rad rms=%0d ovf=%b exp 0,1", r_rms, r_ovf); end
    total++; if (r_mean !== N'(em)) begin bad++; $display("FAIL neg_mean got=%0d exp=%0d", r_mean, em); end
  endtask

  task automatic test_mid_reset();
    bit es; longint em, er;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = N'(1024);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (sqrt_start !== 1'b0) begin bad++; $display("FAIL midrst_sqrt_start got=%b exp=0", sqrt_start); end
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || sqrt_start !== 1'b0) begin
      bad++; $display("FAIL midrst_flags busy=%b in_ready=%b done=%b ovf=%b ss=%b exp all 0", busy, in_ready, done, overflow, sqrt_start); end
    total++; if (mean_sq_q !== '0 || rms_q !== '0 || sqrt_rad_q !== '0) begin
      bad++; $display("FAIL midrst_data mean=%0d rms=%0d rad=%0d exp all 0", mean_sq_q, rms_q, sqrt_rad_q); end
    for (int k = 0; k < LEN; k++) vec[k] = 1024;
    em = ref_mean(es); er = isqrt(em << Q);
    run_vec(0, 0, 0, 0, 1'b0);
    total++; if (r_mean !== N'(em) || r_rms !== N'(er) || em != 1024 || er != 1024) begin
      bad++; $display("FAIL midrst_rerun mean=%0d rms=%0d exp %0d %0d", r_mean, r_rms, em, er); end
    total++; if (r_done_cyc != LEN + 4 + SQ_LAT || r_hs != LEN) begin
      bad++; $display("FAIL midrst_rerun_timing done=%0d hs=%0d exp %0d %0d", r_done_cyc, r_hs, LEN + 4 + SQ_LAT, LEN); end
  endtask

  task automatic test_random();
    bit es; longint em, er;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < LEN; k++) vec[k] = int'($urandom_range(0, 32767)) - 16384;
      em = ref_mean(es); er = isqrt(em << Q);
      run_vec(2, 0, 0, 0, 1'b0);
      total++; if (r_mean !== N'(em) || r_ovf !== es) begin bad++; $display("FAIL rand%0d_mean got=%0d ovf=%b exp=%0d ovf=%b", t, r_mean, r_ovf, em, es); end
      total++; if (r_rms !== N'(er)) begin bad++; $display("FAIL rand%0d_rms got=%0d exp=%0d", t, r_rms, er); end
      total++; if (r_hs != LEN || r_done_cyc != r_last_hs + 4 + SQ_LAT) begin
        bad++; $display("FAIL rand%0d_flow hs=%0d done=%0d last_hs=%0d", t, r_hs, r_done_cyc, r_last_hs); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mixed();
    test_saturate();
    test_backpressure();
    test_sqrt_busy_neg();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
